// File: rtl/sort4_seq_if.sv
// Stream and comparator bundle for sort4_seq: nibble input stream, sorted
// output stream, and the operand/flag lines of the shared external comparator.
interface sort4_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [3:0] cmp_a;
    logic [3:0] cmp_b;
    logic [5:0] cmp_y;

    modport slave (
        input  in_valid, in_data, out_ready, cmp_y,
        output in_ready, out_valid, out_data, cmp_a, cmp_b
    );

    modport master (
        output in_valid, in_data, out_ready, cmp_y,
        input  in_ready, out_valid, out_data, cmp_a, cmp_b
    );
endinterface

// File: rtl/sort4_seq.sv
// Sequential 4-entry nibble sorter: load four values, bubble-sort them through
// an external comparator one pair per cycle, then stream them out.
module sort4_seq #(
    parameter bit DESCEND = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    sort4_seq_if.slave   bus,
    output logic         busy,
    output logic         err
);
    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t     state, state_nx;
    logic [3:0] buf_q [4];
    logic [1:0] cnt, idx, j, pass;
    logic [1:0] j_nx;
    logic       swapped;
    logic       swap;
    logic       cmp_bad;
    logic       pass_end;
    logic       sort_done;
    logic       cmp_ge_le_unused;

    assign j_nx = j + 2'd1;
    assign cmp_ge_le_unused = ^bus.cmp_y[1:0];

    always_comb begin
        state_nx  = state;
        swap      = 1'b0;
        cmp_bad   = 1'b0;
        pass_end  = 1'b0;
        sort_done = 1'b0;
        case (state)
            LOAD: if (bus.in_valid && cnt == 2'd3) state_nx = SORT;
            SORT: begin
                swap      = DESCEND ? bus.cmp_y[2] : bus.cmp_y[3];
                cmp_bad   = (bus.cmp_y[5] == bus.cmp_y[4]) || (bus.cmp_y[3] && bus.cmp_y[2]);
                pass_end  = (j == 2'd2);
                // Early exit only when the whole pass, including this step, was swap-free.
                sort_done = pass_end && (!(swapped || swap) || pass == 2'd2);
                if (sort_done) state_nx = OUT;
            end
            OUT:  if (bus.out_ready && idx == 2'd3) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Outputs are gated by rst_n so they read zero for the whole reset interval.
    always_comb begin
        bus.in_ready  = rst_n && (state == LOAD);
        bus.out_valid = rst_n && (state == OUT);
        busy          = rst_n && (state == SORT);
        bus.out_data  = bus.out_valid ? buf_q[idx] : '0;
        bus.cmp_a     = busy ? buf_q[j]    : '0;
        bus.cmp_b     = busy ? buf_q[j_nx] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            cnt     <= '0;
            idx     <= '0;
            j       <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            err     <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) buf_q[i] <= '0;
        end else begin
            state <= state_nx;
            if (cmp_bad) err <= 1'b1;
            case (state)
                LOAD: begin
                    j       <= '0;
                    pass    <= '0;
                    swapped <= 1'b0;
                    if (bus.in_valid) begin
                        buf_q[cnt] <= bus.in_data;
                        cnt        <= cnt + 2'd1;
                    end
                end
                SORT: begin
                    if (swap) begin
                        buf_q[j]    <= buf_q[j_nx];
                        buf_q[j_nx] <= buf_q[j];
                    end
                    if (pass_end) begin
                        j       <= '0;
                        pass    <= pass + 2'd1;
                        swapped <= 1'b0;
                    end else begin
                        j       <= j_nx;
                        swapped <= swapped || swap;
                    end
                end
                OUT: if (bus.out_ready) idx <= idx + 2'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sort4_seq.sv
// Scoreboard bench for sort4_seq: ascending and descending instances share the
// stimulus, each with its own behavioural comparator.
module tb_sort4_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       out_ready = 1'b1;
    logic       bad0 = 1'b0;
    logic       busy0, err0, busy1, err1;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt0 = 0;
    int busy_cnt1 = 0;
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic       hold0_v = 1'b0, hold1_v = 1'b0;
    logic [3:0] hold0_d = '0, hold1_d = '0;

    always #5 clk = ~clk;

    sort4_seq_if if0();
    sort4_seq_if if1();

    function automatic logic [5:0] cmp_model(input logic [3:0] a, input logic [3:0] b);
        return {a == b, a != b, a > b, a < b, a >= b, a <= b};
    endfunction

    assign if0.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if0.out_ready = out_ready;
    assign if0.cmp_y     = bad0 ? 6'b000000 : cmp_model(if0.cmp_a, if0.cmp_b);
    assign if1.in_valid  = in_valid;
    assign if1.in_data   = in_data;
    assign if1.out_ready = out_ready;
    assign if1.cmp_y     = cmp_model(if1.cmp_a, if1.cmp_b);

    sort4_seq #(.DESCEND(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave), .busy(busy0), .err(err0));
    sort4_seq #(.DESCEND(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1), .err(err1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] sort_vals(input logic [15:0] v, input bit desc);
        logic [3:0] a [4];
        logic [3:0] t;
        for (int i = 0; i < 4; i++) a[i] = v[15 - 4*i -: 4];
        for (int i = 0; i < 4; i++)
            for (int k = i + 1; k < 4; k++)
                if (desc ? (a[k] > a[i]) : (a[k] < a[i])) begin
                    t = a[i]; a[i] = a[k]; a[k] = t;
                end
        return {a[0], a[1], a[2], a[3]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            hold0_v = 1'b0;
            hold1_v = 1'b0;
        end else begin
            if (busy0) busy_cnt0++;
            if (busy1) busy_cnt1++;
            if (!busy0) check("cmp0_idle_zero", {if0.cmp_a, if0.cmp_b}, 0);
            if (!busy1) check("cmp1_idle_zero", {if1.cmp_a, if1.cmp_b}, 0);
            if (busy0) check("sort0_handshakes_low", {if0.in_ready, if0.out_valid}, 0);
            if (hold0_v && if0.out_valid) check("out0_stable", if0.out_data, hold0_d);
            if (hold1_v && if1.out_valid) check("out1_stable", if1.out_data, hold1_d);
            hold0_v = if0.out_valid && !out_ready;
            hold0_d = if0.out_data;
            hold1_v = if1.out_valid && !out_ready;
            hold1_d = if1.out_data;
            if (if0.out_valid && out_ready) begin
                if (q0.size() == 0) check("out0_unexpected", 1, 0);
                else check("out0_data", if0.out_data, q0.pop_front());
            end
            if (if1.out_valid && out_ready) begin
                if (q1.size() == 0) check("out1_unexpected", 1, 0);
                else check("out1_data", if1.out_data, q1.pop_front());
            end
        end
    end

    task automatic drive_val(input logic [3:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load4(input logic [15:0] v);
        logic [15:0] s0, s1;
        @(posedge clk); #1;
        busy_cnt0 = 0;
        busy_cnt1 = 0;
        for (int i = 0; i < 4; i++) drive_val(v[15 - 4*i -: 4]);
        s0 = sort_vals(v, 1'b0);
        s1 = sort_vals(v, 1'b1);
        for (int i = 0; i < 4; i++) begin
            q0.push_back(s0[15 - 4*i -: 4]);
            q1.push_back(s1[15 - 4*i -: 4]);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && if0.in_ready && if1.in_ready) return;
        end
        check("drain_timeout", 0, 1);
    endtask

    task automatic wait_busy0();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (busy0) return;
        end
        check("busy0_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check("rst_in_ready", {if0.in_ready, if1.in_ready}, 0);
        check("rst_out_valid", {if0.out_valid, if1.out_valid}, 0);
        check("rst_busy", {busy0, busy1}, 0);
        check("rst_out_data", {if0.out_data, if1.out_data}, 0);
        check("rst_cmp", {if0.cmp_a, if0.cmp_b, if1.cmp_a, if1.cmp_b}, 0);
        check("rst_err", {err0, err1}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check("post_rst_in_ready", if0.in_ready, 1);

        // Unsorted set; in_valid junk while sorting must not touch the buffer.
        load4(16'h9330);
        wait_busy0();
        in_valid = 1'b1;
        in_data  = 4'hF;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        drain();
        check("busy0_cycles_9330", busy_cnt0, 9);
        check("busy1_cycles_9330", busy_cnt1, 3);

        load4(16'h1234);
        drain();
        check("busy0_cycles_1234", busy_cnt0, 3);
        check("busy1_cycles_1234", busy_cnt1, 9);

        // Back-pressure on the first output word.
        out_ready = 1'b0;
        load4(16'h4132);
        for (int c = 0; c < 50 && !if0.out_valid; c++) @(negedge clk);
        check("hold_out_valid", if0.out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            check("hold_first_value", if0.out_data, q0[0]);
            @(negedge clk);
        end
        check("hold_q0_untouched", q0.size(), 4);
        out_ready = 1'b1;
        drain();

        // One bad comparator response sets the sticky error.
        load4(16'h2143);
        wait_busy0();
        bad0 = 1'b1;
        @(posedge clk); #1;
        bad0 = 1'b0;
        check("err0_set", err0, 1);
        drain();
        check("err0_sticky", err0, 1);
        check("err1_clear", err1, 0);

        // Reset mid-LOAD.
        @(posedge clk); #1;
        drive_val(4'hA);
        drive_val(4'hB);
        do_reset();
        load4(16'h5476);
        drain();

        // Reset mid-SORT.
        load4(16'h8810);
        wait_busy0();
        do_reset();
        load4(16'h5476);
        drain();
        check("err0_after_reset", err0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sort4_seq.md
SORT4_SEQ -- requirements
Module: sort4_seq

Interface
REQ-001 Parameter DESCEND, default 0: 0 = ascending output order, 1 = descending output order.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  in_data is valid this cycle.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  4  unsigned nibble to be sorted.
REQ-007 out_valid  output  1  out_data is valid this cycle.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  4  sorted nibble.
REQ-010 cmp_a, cmp_b  output  4 each  operands driven to the shared 4-bit comparator.
REQ-011 cmp_y  input  6  comparator flags: [5] eq, [4] ne, [3] a>b, [2] a<b, [1] a>=b, [0] a<=b.
REQ-012 busy  output  1  high in the SORT state.
REQ-013 err  output  1  sticky comparator-inconsistency flag.

Function
REQ-014 The block shall hold a 4-entry x 4-bit buffer buf[0..3] and implement three states: LOAD, SORT, OUT.
REQ-015 LOAD: in_ready = 1; each cycle with in_valid && in_ready writes in_data to buf[cnt] and increments cnt (2-bit count); the 4th transfer resets cnt to 0 and moves the block to SORT on the next edge.
REQ-016 SORT: the block shall perform bubble-sort compare steps, one pair per cycle, in the order j = 0, 1, 2 within a pass; cmp_a = buf[j] and cmp_b = buf[j+1] combinationally.
REQ-017 Swap condition: cmp_y[3] when DESCEND = 0, cmp_y[2] when DESCEND = 1; on swap, buf[j] and buf[j+1] are exchanged at the clock edge; equal operands are never swapped.
REQ-018 After step j = 2, when the pass recorded no swap, or when 3 passes have completed, the block shall move to OUT; otherwise it starts the next pass at j = 0.
REQ-019 SORT latency: minimum 3 cycles (already-sorted input), maximum 9 cycles; in_ready = 0 and out_valid = 0 throughout SORT.
REQ-020 OUT: out_valid = 1 and out_data = buf[idx]; idx increments on out_valid && out_ready; after the 4th transfer the block returns to LOAD with idx = 0.
REQ-021 out_data shall remain stable while out_valid && !out_ready.
REQ-022 Outside SORT, cmp_a and cmp_b shall be 0.
REQ-023 In SORT, when cmp_y[5] == cmp_y[4], or cmp_y[3] && cmp_y[2], the block shall set err = 1; err stays set until reset and does not alter sequencing.
REQ-024 in_valid in SORT or OUT shall be ignored, and no buffer entry changes.
REQ-025 out_ready in LOAD or SORT shall be ignored.

Reset
REQ-026 While rst_n = 0, the block shall force state = LOAD, cnt = idx = j = pass = 0, buf[0..3] = 0, err = 0.
REQ-027 While rst_n = 0, the block shall drive in_ready = 0, out_valid = 0, busy = 0, and out_data = cmp_a = cmp_b = 0.
REQ-028 Reset asserted mid-LOAD, mid-SORT or mid-OUT shall discard all partial data; after release the first accepted value goes to buf[0].

Verification
REQ-029 Load 9,3,3,0 (DESCEND = 0) with a correct comparator model -> output 0,3,3,9; busy high for 9 cycles.
REQ-030 Load 1,2,3,4 (DESCEND = 0) -> busy high for exactly 3 cycles; output 1,2,3,4; no swaps occur.
REQ-031 Load 1,2,3,4 (DESCEND = 1) -> output 4,3,2,1.
REQ-032 Hold out_ready = 0 for 5 cycles on the first output -> out_data held at the first value, idx unchanged; 4 values follow once out_ready = 1.
REQ-033 Force cmp_y = 6'b000000 during one SORT cycle -> err = 1 on the next edge and held until rst_n = 0.
REQ-034 Assert rst_n = 0 during SORT after 2 loads of a set; reload 5,4,7,6 -> output 4,5,6,7 with no stale data.
